sdram_ctrl: RTL

//  Single-port controller for the DE1 16-bit SDRAM (4 banks x 8192 rows x 1024 cols), clocked at 100 MHz.

---
 rtl/sdram_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_ctrl.sv
// sdram_ctrl: closed-page, single-port controller for the DE1 16-bit SDRAM.
// Runs power-up init, periodic auto-refresh and one-word read/write accesses.
module sdram_ctrl #(
    parameter int T_INIT    = 10010,
    parameter int INIT_REFS = 8,
    parameter int T_REFI    = 780,
    parameter int T_RP      = 2,
    parameter int T_RCD     = 2,
    parameter int T_RC      = 8,
    parameter int T_MRD     = 2,
    parameter int CAS_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [24:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        init_done,
    output logic [12:0] sd_addr,
    output logic [1:0]  sd_ba,
    output logic        sd_cs_n,
    output logic        sd_ras_n,
    output logic        sd_cas_n,
    output logic        sd_we_n,
    output logic [1:0]  sd_dqm,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    input  logic [15:0] dq_in
);
    typedef enum logic [2:0] {
        INIT_WAIT, INIT_PRE, INIT_REF, INIT_MRS,
        IDLE, REFRESH, ACT, RW
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    // single-location writes, sequential burst of 1
    localparam logic [14:0] MODE = {5'd0, 1'b1, 2'b00, 3'(CAS_LAT), 1'b0, 3'd0};

    state_t             state;
    logic [15:0]        cnt;
    logic [3:0]         ref_cnt;
    logic [9:0]         refi_cnt;
    logic               ref_pend;
    logic               refi_hit;
    logic [1:0]         l_ba;
    logic [9:0]         l_col;
    logic               l_we;
    logic [15:0]        l_wdata;
    logic [1:0]         l_be;
    logic [CAS_LAT:0]   rd_pipe;

    assign refi_hit = init_done && (refi_cnt == 10'(T_REFI - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT_WAIT;
            cnt       <= 16'(T_INIT - 1);
            ref_cnt   <= '0;
            refi_cnt  <= '0;
            ref_pend  <= 1'b0;
            l_ba      <= '0;
            l_col     <= '0;
            l_we      <= 1'b0;
            l_wdata   <= '0;
            l_be      <= '0;
            rd_pipe   <= '0;
            {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_NOP;
            sd_addr   <= '0;
            sd_ba     <= '0;
            sd_dqm    <= 2'b11;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            req_ready <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            init_done <= 1'b0;
        end else begin
            {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_NOP;
            sd_dqm   <= (|rd_pipe[CAS_LAT-1:0]) ? 2'b00 : 2'b11;
            dq_oe    <= 1'b0;
            rd_pipe  <= {rd_pipe[CAS_LAT-1:0], 1'b0};
            rd_valid <= rd_pipe[CAS_LAT];
            if (rd_pipe[CAS_LAT])
                rd_data <= dq_in;

            // refresh timer keeps running through accesses
            if (!init_done || refi_hit)
                refi_cnt <= '0;
            else
                refi_cnt <= refi_cnt + 10'd1;
            if (refi_hit)
                ref_pend <= 1'b1;

            if (cnt != 16'd0)
                cnt <= cnt - 16'd1;

            unique case (state)
                INIT_WAIT: if (cnt == 16'd0) begin
                    state   <= INIT_PRE;
                    {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_PRE;
                    sd_addr <= 13'h0400;
                    cnt     <= 16'(T_RP - 1);
                end
                INIT_PRE: if (cnt == 16'd0) begin
                    state   <= INIT_REF;
                    {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_REF;
                    ref_cnt <= '0;
                    cnt     <= 16'(T_RC - 1);
                end
                INIT_REF: if (cnt == 16'd0) begin
                    if (ref_cnt == 4'(INIT_REFS - 1)) begin
                        state <= INIT_MRS;
                        {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_MRS;
                        {sd_ba, sd_addr} <= MODE;
                        cnt   <= 16'(T_MRD - 1);
                    end else begin
                        {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_REF;
                        ref_cnt <= ref_cnt + 4'd1;
                        cnt     <= 16'(T_RC - 1);
                    end
                end
                INIT_MRS: if (cnt == 16'd0) begin
                    state     <= IDLE;
                    init_done <= 1'b1;
                    req_ready <= ~(ref_pend | refi_hit);
                end
                IDLE: begin
                    if (ref_pend) begin
                        state     <= REFRESH;
                        {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_REF;
                        ref_pend  <= refi_hit;
                        req_ready <= 1'b0;
                        cnt       <= 16'(T_RC - 1);
                    end else if (req_valid && req_ready) begin
                        state     <= ACT;
                        {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_ACT;
                        sd_ba     <= req_addr[24:23];
                        sd_addr   <= req_addr[22:10];
                        l_ba      <= req_addr[24:23];
                        l_col     <= req_addr[9:0];
                        l_we      <= req_we;
                        l_wdata   <= req_wdata;
                        l_be      <= req_be;
                        req_ready <= 1'b0;
                        cnt       <= 16'(T_RCD - 1);
                    end else begin
                        req_ready <= ~refi_hit;
                    end
                end
                REFRESH: if (cnt == 16'd0) begin
                    state     <= IDLE;
                    req_ready <= ~(ref_pend | refi_hit);
                end
                ACT: if (cnt == 16'd0) begin
                    state   <= RW;
                    sd_ba   <= l_ba;
                    sd_addr <= {2'b00, 1'b1, l_col};
                    cnt     <= 16'(T_RC - T_RCD - 1);
                    if (l_we) begin
                        {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_WR;
                        dq_oe  <= 1'b1;
                        dq_out <= l_wdata;
                        sd_dqm <= ~l_be;
                    end else begin
                        {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_RD;
                        sd_dqm     <= 2'b00;
                        rd_pipe[0] <= 1'b1;
                    end
                end
                RW: if (cnt == 16'd0) begin
                    state     <= IDLE;
                    req_ready <= ~(ref_pend | refi_hit);
                end
            endcase
        end
    end
endmodule
